// File: rtl/spectrum_frame_buffer.sv
// Ping-pong spectrum level buffer with per-bin peak hold and linear decay.
// A write FSM clears all memories after reset, aligns to the first frame
// boundary, then stores each magnitude frame into the write bank while the
// display renderer reads the other bank through a 1-cycle-latency port.
module spectrum_frame_buffer #(
  parameter int POINTS = 256,
  parameter int AW     = 8,
  parameter int DECAY  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [8:0]    data_modulus,
  input  logic          data_valid,
  input  logic          data_eop,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [8:0]    rd_level,
  output logic [8:0]    rd_peak,
  output logic          rd_valid,
  output logic          frame_done,
  output logic          short_frame,
  output logic          busy,
  output logic [7:0]    frame_cnt
);

  typedef enum logic [1:0] {CLEAR, SYNC, FILL} state_t;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(POINTS);
  localparam logic [AW:0]   CNT_LAST = (AW+1)'(POINTS - 1);
  localparam logic [AW-1:0] ADDR_END = AW'(POINTS - 1);
  localparam logic [8:0]    DEC9     = 9'(DECAY);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic          store_d, swap_d, short_d;

  // Stage-1 registers: sample, its bin index and the frame-end decision.
  logic          s1_store, s1_swap, s1_short;
  logic [AW-1:0] s1_idx;
  logic [8:0]    s1_data;
  logic [8:0]    peak_rmw;
  logic [8:0]    peak_dec, peak_new;
  logic          wr_bank;

  logic [8:0] bank0    [POINTS];
  logic [8:0] bank1    [POINTS];
  logic [8:0] peak_mem [POINTS];

  // Shared write port signals for the three memories.
  logic          we_bank0, we_bank1, we_peak;
  logic [AW-1:0] mem_waddr;
  logic [8:0]    wdata_level, wdata_peak;

  assign busy = (state_q == CLEAR);

  // Write FSM: next state, fill counter and per-sample store/eop decisions.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_cnt_d   = wr_cnt_q;
    store_d    = 1'b0;
    swap_d     = 1'b0;
    short_d    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == ADDR_END) state_d = SYNC;
      end
      SYNC: begin
        if (data_valid && data_eop) begin
          state_d  = FILL;
          wr_cnt_d = '0;
        end
      end
      FILL: begin
        if (data_valid) begin
          store_d = (wr_cnt_q < CNT_FULL);
          if (store_d) wr_cnt_d = wr_cnt_q + (AW+1)'(1);
          if (data_eop) begin
            wr_cnt_d = '0;
            // Full when the eop sample itself fills the last bin or the
            // frame already saturated before it.
            if (wr_cnt_q >= CNT_LAST) swap_d  = 1'b1;
            else                      short_d = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // FSM state, clear sweep address and fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Input stage: capture the sample with its bin index and eop outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_store <= 1'b0;
      s1_swap  <= 1'b0;
      s1_short <= 1'b0;
      s1_idx   <= '0;
      s1_data  <= '0;
    end else begin
      s1_store <= store_d;
      s1_swap  <= swap_d;
      s1_short <= short_d;
      s1_idx   <= wr_cnt_q[AW-1:0];
      s1_data  <= data_modulus;
    end
  end

  // Peak read half of the read-modify-write, issued alongside the input stage.
  always_ff @(posedge clk) begin
    peak_rmw <= peak_mem[wr_cnt_q[AW-1:0]];
  end

  // New peak = max(sample, held peak decayed and clamped at zero).
  always_comb begin
    peak_dec    = (peak_rmw > DEC9) ? (peak_rmw - DEC9) : 9'd0;
    peak_new    = (s1_data > peak_dec) ? s1_data : peak_dec;
    we_bank0    = busy || (s1_store && !wr_bank);
    we_bank1    = busy || (s1_store &&  wr_bank);
    we_peak     = busy || s1_store;
    mem_waddr   = busy ? clr_addr_q : s1_idx;
    wdata_level = busy ? 9'd0 : s1_data;
    wdata_peak  = busy ? 9'd0 : peak_new;
  end

  // Level bank 0 write port.
  always_ff @(posedge clk) begin
    // NOTE: memories carry no reset; the CLEAR sweep zeroes them so they
    // still map onto block RAM.
    if (we_bank0) bank0[mem_waddr] <= wdata_level;
  end

  // Level bank 1 write port.
  always_ff @(posedge clk) begin
    if (we_bank1) bank1[mem_waddr] <= wdata_level;
  end

  // Peak array write port.
  always_ff @(posedge clk) begin
    if (we_peak) peak_mem[mem_waddr] <= wdata_peak;
  end

  // Frame completion: bank swap, done pulse, frame count and sticky short flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      short_frame <= 1'b0;
    end else begin
      frame_done <= s1_swap;
      if (s1_swap) begin
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (s1_short) short_frame <= 1'b1;
    end
  end

  // Display read port: one cycle latency, zeros while memories are clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_level <= '0;
      rd_peak  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (busy) begin
          rd_level <= '0;
          rd_peak  <= '0;
        end else begin
          rd_level <= wr_bank ? bank0[rd_addr] : bank1[rd_addr];
          rd_peak  <= peak_mem[rd_addr];
        end
      end
    end
  end

endmodule
